// File: rtl/module_serial_subtractor_pkg.sv
// Shared types and limits for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkg_serial_subtractor;

    // Control FSM states of the serial subtractor.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Supported operand width range.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/module_serial_subtractor_bit.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs.
module module_bit_full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_i,
    output logic diff_o,
    output logic borrow_o
);

    // Borrow is generated when a=0,b=1 and propagated when a==b.
    assign diff_o   = a_i ^ b_i ^ borrow_i;
    assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);

endmodule

// File: rtl/module_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B - bin, LSB first); SERIAL_SUBTRACTOR_OVERFLOW_EN adds signed overflow.
// Latency: out_valid_o rises WIDTH cycles after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: result held in DONE until out_ready_i; in_ready_o low from accept until release.
module module_serial_subtractor
    import pkg_serial_subtractor::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_width_check
        $fatal(1, "module_serial_subtractor: WIDTH %0d outside supported range", WIDTH);
    end

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic               borrow_q;
    logic               borrow_d;
    logic               diff_bit_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;

    // One cell evaluates the current bit pair against the running borrow.
    module_bit_full_subtractor u_cell (
        .a_i      (a_q[0]),
        .b_i      (b_q[0]),
        .borrow_i (borrow_q),
        .diff_o   (diff_bit_d),
        .borrow_o (borrow_d)
    );

    // Result fills from the MSB side so that after WIDTH shifts bit 0 is the first computed bit.
    assign res_d = {diff_bit_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic ovf_q;

    // Overflow is decided on the final bit, where a_q[0]/b_q[0] still hold the operand MSBs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if ((state_q == BUSY) && (cnt_q == CNT_LAST)) begin
            ovf_q <= (a_q[0] != b_q[0]) && (diff_bit_d != a_q[0]);
        end else if ((state_q == DONE) && out_ready_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow_o = ovf_q & out_valid_q;
`else
    assign overflow_o = 1'b0;
`endif

    // Control FSM plus shift datapath; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        borrow_q <= borrow_i;
                        res_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    borrow_q <= borrow_d;
                    res_q    <= res_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready only in IDLE and never while reset is held, so accept and release cannot overlap.
    assign in_ready_o  = (state_q == IDLE) && !rst_i;
    assign out_valid_o = out_valid_q;
    // Partial results during BUSY are masked; outputs read zero unless the result is valid.
    assign diff_o      = out_valid_q ? res_q : '0;
    assign borrow_o    = borrow_q & out_valid_q;

endmodule

// File: tb/tb_module_serial_subtractor.sv
module tb_module_serial_subtractor;

    localparam int WIDTH = 8;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             borrow_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;
    logic             overflow_o;

    logic ca, cb, cbin, cd, cbo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    module_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .borrow_i    (borrow_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .diff_o      (diff_o),
        .borrow_o    (borrow_o),
        .overflow_o  (overflow_o)
    );

    module_bit_full_subtractor u_cell (
        .a_i      (ca),
        .b_i      (cb),
        .borrow_i (cbin),
        .diff_o   (cd),
        .borrow_o (cbo)
    );

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [2:0] abb;
        logic       d;
        logic       bo;
    } cell_vec_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one operation, hold the result rdelay cycles, then release and compare.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                          input exp_t e, input int rdelay);
        int               cnt;
        exp_t             got;
        logic [WIDTH-1:0] hold_d;
        logic             hold_b;
        chk("in_ready_idle", {31'd0, in_ready_o}, 32'd1);
        a_i = a; b_i = b; borrow_i = bin; in_valid_i = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid_i = 1'b0;
        a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); borrow_i = 1'($urandom);
        cnt = 0;
        while (!out_valid_o && cnt < 4 * WIDTH) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!out_valid_o) begin
            chk("out_valid_timeout", {31'd0, out_valid_o}, 32'd1);
            void'(sb.pop_front());
            return;
        end
        chk("latency", cnt, WIDTH);
        hold_d = diff_o;
        hold_b = borrow_o;
        for (int k = 0; k < rdelay; k++) begin
            in_valid_i = 1'b1;
            chk("in_ready_done", {31'd0, in_ready_o}, 32'd0);
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid_o}, 32'd1);
            chk("hold_diff", {24'd0, diff_o}, {24'd0, hold_d});
            chk("hold_borrow", {31'd0, borrow_o}, {31'd0, hold_b});
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        got = sb.pop_front();
        chk("diff", {24'd0, diff_o}, {24'd0, got.diff});
        chk("borrow", {31'd0, borrow_o}, {31'd0, got.bout});
        chk("overflow", {31'd0, overflow_o}, {31'd0, got.ovf});
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        chk("release_valid", {31'd0, out_valid_o}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready_o}, 32'd1);
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        logic [WIDTH:0] full;
        exp_t           r;
        full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        r.diff = full[WIDTH-1:0];
        r.bout = full[WIDTH];
        r.ovf  = OVF_EN & (a[WIDTH-1] != b[WIDTH-1]) & (full[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cell_vec_t cv[8];
        vec_t      vecs[8];
        exp_t      e;
        int        first_acc;
        bit        seen;
        logic [WIDTH-1:0] ra, rb;
        logic             rbin;

        cv[0] = '{3'b000, 1'b0, 1'b0};
        cv[1] = '{3'b001, 1'b1, 1'b1};
        cv[2] = '{3'b010, 1'b1, 1'b1};
        cv[3] = '{3'b011, 1'b0, 1'b1};
        cv[4] = '{3'b100, 1'b1, 1'b0};
        cv[5] = '{3'b101, 1'b0, 1'b0};
        cv[6] = '{3'b110, 1'b0, 1'b0};
        cv[7] = '{3'b111, 1'b1, 1'b1};

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h12, 8'hFF, 1'b1, 8'h12, 1'b1, 1'b0};
        vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
        a_i = '0; b_i = '0; borrow_i = 1'b0;
        ca = 1'b0; cb = 1'b0; cbin = 1'b0;

        // Exhaustive cell check.
        for (int i = 0; i < 8; i++) begin
            {ca, cb, cbin} = cv[i].abb;
            #1;
            chk("cell_diff", {31'd0, cd}, {31'd0, cv[i].d});
            chk("cell_borrow", {31'd0, cbo}, {31'd0, cv[i].bo});
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_diff", {24'd0, diff_o}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_o}, 32'd0);
        chk("rst_overflow", {31'd0, overflow_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);

        // Directed table with an always-ready consumer.
        for (int i = 0; i < 8; i++) begin
            e.diff = vecs[i].diff;
            e.bout = vecs[i].bout;
            e.ovf  = vecs[i].ovf & OVF_EN;
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, e, 0);
        end

        // Throughput: back-to-back ops with ready held high.
        run_op(8'h33, 8'h11, 1'b0, model(8'h33, 8'h11, 1'b0), 0);
        first_acc = acc_cyc;
        run_op(8'h10, 8'h20, 1'b1, model(8'h10, 8'h20, 1'b1), 0);
        chk("throughput", acc_cyc - first_acc, WIDTH + 2);

        // Backpressure: five cycles held in DONE with in_valid asserted.
        run_op(8'hA5, 8'h3C, 1'b1, model(8'hA5, 8'h3C, 1'b1), 5);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_extra_accept", {31'd0, out_valid_o}, 32'd0);
        chk("bp_idle_ready", {31'd0, in_ready_o}, 32'd1);

        // Reset on the 4th BUSY cycle aborts the operation.
        a_i = 8'h44; b_i = 8'h22; borrow_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("abort_diff", {24'd0, diff_o}, 32'd0);
        chk("abort_borrow", {31'd0, borrow_o}, 32'd0);
        chk("abort_overflow", {31'd0, overflow_o}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("abort_in_ready_after", {31'd0, in_ready_o}, 32'd1);
        seen = 1'b0;
        repeat (2 * WIDTH) begin
            @(posedge clk); #1;
            if (out_valid_o) seen = 1'b1;
        end
        chk("abort_no_valid", {31'd0, seen}, 32'd0);

        // Random regression with random consumer delay.
        for (int i = 0; i < 200; i++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rbin = 1'($urandom);
            run_op(ra, rb, rbin, model(ra, rb, rbin), $urandom_range(0, 3));
            if (n_fail != 0) begin
                $display("FAIL random regression: op %0d a=%0h b=%0h bin=%0d", i, ra, rb, rbin);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $fatal(1, "random regression stopped");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/module_serial_subtractor.md
Name: module_serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes A - B - borrow_in one bit per clock, LSB first.
- Built around a single-bit full subtractor, the inverse counterpart of the team's full adder cell.
- Valid/ready on both input and output sides.
- Used where area matters more than latency, for example in decrement/compare paths next to the serial adder datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- in_valid_i  input  1  operands present.
- in_ready_o  output  1  block can accept operands.
- a_i  input  WIDTH  minuend.
- b_i  input  WIDTH  subtrahend.
- borrow_i  input  1  borrow-in.
- out_valid_o  output  1  result available.
- out_ready_i  input  1  consumer accepts result.
- diff_o  output  WIDTH  (a_i - b_i - borrow_i) mod 2^WIDTH.
- borrow_o  output  1  1 iff a_i < b_i + borrow_i (unsigned).
- overflow_o  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: in_ready_o=0 during reset and 1 the first cycle after. out_valid_o=0, diff_o=0, borrow_o=0, overflow_o=0. Internal shift registers, counter and borrow flop cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready_o=1.
  - On an edge with in_valid_i=1, capture a_i, b_i, borrow_i. Clear bit counter and go to BUSY.
  - in_valid_i without a handshake has no effect.
- BUSY:
  - in_ready_o=0.
  - Each edge: feed LSB of the A/B shift registers plus the borrow flop into module_bit_full_subtractor.
  - Shift the difference bit into the result register MSB-side (result shifts right).
  - Register borrow-out, increment counter.
  - On the edge where counter==WIDTH-1, go to DONE.
- DONE:
  - out_valid_o=1. diff_o, borrow_o, overflow_o are held stable until out_ready_i=1.
  - On an edge with out_ready_i=1, go to IDLE and drop out_valid_o.
  - in_ready_o=0 in DONE, so no overlap of accept and release.
- Latency: out_valid_o rises exactly WIDTH cycles after the accepting edge. Throughput is one operation per WIDTH+2 cycles when the consumer is always ready.
- Full subtractor cell equations: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
- Boundary cases:
  - a==b, bin=0: diff 0, borrow 0.
  - a=0, b=0, bin=1: diff all-ones, borrow 1.
  - b all-ones, bin=1: wraps correctly. No internal width extension is required because the serial borrow chain handles it.
- Counter width: $clog2(WIDTH). It must not wrap before the DONE transition.
- Reset mid-operation (BUSY or DONE): abort. All outputs take their reset values on the next edge and no partial result is ever flagged valid.
- in_valid_i or operand changes during BUSY or DONE are ignored.
- out_ready_i during IDLE or BUSY is ignored.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- When defined: overflow_o in DONE = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands and the final result. It is registered with the result and held with it.
- When undefined: overflow_o tied to 0 and no extra flops are inferred. The port list is unchanged.

Decomposition:
- Package pkg_serial_subtractor contains:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t.
  - localparam WIDTH_MIN = 2 and WIDTH_MAX = 32.
- Sub-module module_bit_full_subtractor: ports a_i, b_i, borrow_i, diff_o, borrow_o. It is purely combinational, instantiated once, and also unit-tested exhaustively (8 vectors).
- Elaboration-time check: $fatal if WIDTH is outside [WIDTH_MIN, WIDTH_MAX].

Test Plan:
- Basic subtract: WIDTH=8, a=8'h05, b=8'h03, bin=0, out_ready_i=1 -> diff_o=8'h02, borrow_o=0, out_valid_o rising exactly 8 cycles after accept.
- Underflow: a=8'h00, b=8'h01, bin=0 -> diff_o=8'hFF, borrow_o=1. Then a=8'h00, b=8'h00, bin=1 -> diff_o=8'hFF, borrow_o=1.
- Signed overflow: a=8'h80, b=8'h01 -> diff_o=8'h7F, borrow_o=0, overflow_o=1 with macro and 0 without. Also a=8'h7F, b=8'hFF -> diff_o=8'h80, overflow_o=1 with macro.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> diff_o, borrow_o and out_valid_o stable; in_ready_o=0; a new in_valid_i is not accepted. Release -> IDLE one cycle later.
- Reset mid-BUSY: assert rst_i on the 4th BUSY cycle -> next edge all outputs 0; in_ready_o=1 the cycle after rst_i drops; no out_valid_o pulse.
- Random regression: 200 random a/b/bin with randomised out_ready_i delays (0-3 cycles) -> each result matches {borrow, diff} = a - b - bin computed in WIDTH+1 bits. The bench stops with $fatal on the first mismatch.
